// File: rtl/timer_counter_if.sv
// Bus interface for timer_counter: word address, write strobe, write data,
// combinational read data and the interrupt request line.
interface timer_counter_if;
  logic [31:2] Addr;
  logic        WE;
  logic [31:0] Din;
  logic [31:0] Dout;
  logic        IRQ;

  modport master (output Addr, WE, Din, input Dout, IRQ);
  modport slave  (input Addr, WE, Din, output Dout, IRQ);
endinterface

// File: rtl/timer_counter.sv
// timer_counter: memory-mapped down-counter with one-shot (mode 0/2/3) and
// auto-reload (mode 1) operation and a maskable interrupt.
// Registers: 0 CTRL {IM, MODE[1:0], EN}, 1 PRESET, 2 COUNT (read-only),
// 3 reserved. Optional macro TC_STATUS_EN turns offset 3 into a status
// register reading {31'b0, irq_flag} with write-1-to-clear on bit 0.
module timer_counter (
  input  logic           clk,
  input  logic           reset,
  timer_counter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    CNT  = 2'd2,
    INT  = 2'd3
  } state_t;

  localparam logic [1:0] SEL_CTRL   = 2'd0;
  localparam logic [1:0] SEL_PRESET = 2'd1;
  localparam logic [1:0] SEL_COUNT  = 2'd2;
  localparam logic [1:0] MODE_RELOAD = 2'd1;

  state_t      state_q, state_d;
  logic [3:0]  ctrl_q, ctrl_d;
  logic [31:0] preset_q, preset_d;
  logic [31:0] count_q, count_d;
  logic        irq_flag_q, irq_flag_d;
  logic        expire;

  logic [1:0]  sel;
  logic        wr_ctrl;
  logic        wr_preset;
  logic [31:0] dout;

  // Upper address bits are intentionally not decoded.
  logic        unused_addr;
  assign unused_addr = ^bus.Addr[31:4];

  assign sel       = bus.Addr[3:2];
  assign wr_ctrl   = bus.WE && (sel == SEL_CTRL);
  assign wr_preset = bus.WE && (sel == SEL_PRESET);

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic together with the counter and flag updates it drives.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    expire  = 1'b0;
    case (state_q)
      IDLE: begin
        if (ctrl_q[0]) state_d = LOAD;
      end
      LOAD: begin
        count_d = preset_q;
        state_d = CNT;
      end
      CNT: begin
        if (!ctrl_q[0]) begin
          state_d = IDLE;
        end else if (count_q > 32'd1) begin
          count_d = count_q - 32'd1;
        end else begin
          // PRESET=0 lands here on the first CNT cycle, behaving like PRESET=1.
          count_d = '0;
          expire  = 1'b1;
          state_d = INT;
        end
      end
      INT: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // CPU-visible register next values; a CPU write to CTRL beats the FSM's EN clear.
  always_comb begin
    ctrl_d     = ctrl_q;
    preset_d   = preset_q;
    irq_flag_d = irq_flag_q;

    if (state_q == INT) begin
      if (ctrl_q[2:1] == MODE_RELOAD) begin
        irq_flag_d = 1'b0;
      end else begin
        ctrl_d[0] = 1'b0;
      end
    end

    if (wr_ctrl) begin
      ctrl_d     = bus.Din[3:0];
      irq_flag_d = 1'b0;
    end

    if (wr_preset) begin
      preset_d   = bus.Din;
      irq_flag_d = 1'b0;
    end

`ifdef TC_STATUS_EN
    if (bus.WE && (sel == 2'd3) && bus.Din[0]) begin
      irq_flag_d = 1'b0;
    end
`endif

    // Expiry on the same edge as a clearing write still raises the flag.
    if (expire) begin
      irq_flag_d = 1'b1;
    end
  end

  // Register file, counter and interrupt flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_q     <= '0;
      preset_q   <= '0;
      count_q    <= '0;
      irq_flag_q <= 1'b0;
    end else begin
      ctrl_q     <= ctrl_d;
      preset_q   <= preset_d;
      count_q    <= count_d;
      irq_flag_q <= irq_flag_d;
    end
  end

  // Combinational read mux.
  always_comb begin
    dout = '0;
    case (sel)
      SEL_CTRL:   dout = {28'd0, ctrl_q};
      SEL_PRESET: dout = preset_q;
      SEL_COUNT:  dout = count_q;
      default: begin
`ifdef TC_STATUS_EN
        dout = {31'd0, irq_flag_q};
`else
        dout = '0;
`endif
      end
    endcase
  end

  assign bus.Dout = dout;
  assign bus.IRQ  = irq_flag_q & ctrl_q[3];

endmodule

// File: tb/tb_timer_counter.sv
// Testbench for timer_counter: directed scenarios plus randomized bus traffic,
// all compared against a timeline-based reference model.
module tb_timer_counter;

  logic clk;
  logic reset;

  timer_counter_if bus ();

  timer_counter dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: register contents plus a timeline of the current run.
  logic [3:0]  m_ctrl;
  logic [31:0] m_preset;
  logic [31:0] m_count;
  logic        m_flag;
  bit          m_busy;      // armed: started at edge m_arm
  bit          m_post;      // the edge after expiry is pending
  longint      m_arm;
  longint      m_n;         // preset captured at the load edge
  longint      cyc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_vec++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", tag, obs, exp_v, cyc);
    end
  endtask

  function automatic logic [31:0] mdl_rd(input logic [1:0] a);
    case (a)
      2'd0: return {28'd0, m_ctrl};
      2'd1: return m_preset;
      2'd2: return m_count;
      default: begin
`ifdef TC_STATUS_EN
        return {31'd0, m_flag};
`else
        return 32'd0;
`endif
      end
    endcase
  endfunction

  // One clock edge of the model. Run j edges after arming: j=0 loads PRESET,
  // then COUNT = N-j until j reaches max(N,1), which is the expiry edge.
  task automatic mdl_edge(input bit r, input bit we, input logic [1:0] a, input logic [31:0] d);
    logic [3:0]  n_ctrl;
    logic [31:0] n_pre, n_cnt;
    logic        n_flag;
    bit          set;
    longint      j, lim;
    cyc++;
    if (r) begin
      m_ctrl = '0; m_preset = '0; m_count = '0; m_flag = 1'b0;
      m_busy = 0; m_post = 0;
      return;
    end
    n_ctrl = m_ctrl; n_pre = m_preset; n_cnt = m_count; n_flag = m_flag; set = 0;
    if (m_post) begin
      m_post = 0;
      if (m_ctrl[2:1] == 2'd1) n_flag = 1'b0;
      else n_ctrl[0] = 1'b0;
    end else if (m_busy) begin
      j = cyc - m_arm - 1;
      if (j == 0) begin
        m_n   = longint'(m_preset);
        n_cnt = m_preset;
      end else if (!m_ctrl[0]) begin
        m_busy = 0;
      end else begin
        lim = (m_n == 0) ? 1 : m_n;
        if (j >= lim) begin
          n_cnt = '0; set = 1; m_busy = 0; m_post = 1;
        end else begin
          n_cnt = 32'(m_n - j);
        end
      end
    end else if (m_ctrl[0]) begin
      m_busy = 1;
      m_arm  = cyc;
    end
    if (we) begin
      case (a)
        2'd0: begin n_ctrl = d[3:0]; n_flag = 1'b0; end
        2'd1: begin n_pre = d; n_flag = 1'b0; end
        2'd3: begin
`ifdef TC_STATUS_EN
          if (d[0]) n_flag = 1'b0;
`endif
        end
        default: ;
      endcase
    end
    if (set) n_flag = 1'b1;
    m_ctrl = n_ctrl; m_preset = n_pre; m_count = n_cnt; m_flag = n_flag;
  endtask

  // Apply one bus cycle, advance DUT and model, then compare read data and IRQ.
  task automatic cycle(input bit r, input bit we, input logic [1:0] a, input logic [31:0] d);
    logic [27:0] hi;
    hi        = 28'($urandom);
    reset     = r;
    bus.WE    = we;
    bus.Addr  = {hi, a};
    bus.Din   = d;
    @(posedge clk);
    mdl_edge(r, we, a, d);
    #1;
    chk($sformatf("dout[%0d]", a), bus.Dout, mdl_rd(a));
    chk("irq", {31'd0, bus.IRQ}, {31'd0, m_flag & m_ctrl[3]});
    reset  = 1'b0;
    bus.WE = 1'b0;
  endtask

  task automatic do_reset();
    cycle(1'b1, 1'b0, 2'd0, 32'd0);
    cycle(1'b1, 1'b0, 2'd0, 32'd0);
  endtask

  logic [31:0] frozen;

  initial begin
    cyc = 0; m_busy = 0; m_post = 0; m_arm = 0; m_n = 0;
    m_ctrl = '0; m_preset = '0; m_count = '0; m_flag = 1'b0;
    reset = 1'b1; bus.WE = 1'b0; bus.Addr = '0; bus.Din = '0;

    // Reset state.
    do_reset();
    for (int a = 0; a < 3; a++) begin
      cycle(1'b0, 1'b0, 2'(a), 32'd0);
      chk("rst_read", bus.Dout, 32'd0);
      chk("rst_irq", {31'd0, bus.IRQ}, 32'd0);
    end

    // One-shot, PRESET=5, IM=1: COUNT 5..0, IRQ after E7, EN cleared.
    cycle(1'b0, 1'b1, 2'd1, 32'd5);
    cycle(1'b0, 1'b1, 2'd0, 32'h9);             // E0
    for (int k = 1; k <= 10; k++) begin
      cycle(1'b0, 1'b0, 2'd2, 32'd0);
      if (k >= 2 && k <= 7) chk("m0_count", bus.Dout, 32'(7 - k));
      chk("m0_irq", {31'd0, bus.IRQ}, (k >= 7) ? 32'd1 : 32'd0);
    end
    cycle(1'b0, 1'b0, 2'd0, 32'd0);
    chk("m0_ctrl", bus.Dout, 32'h8);
    cycle(1'b0, 1'b1, 2'd0, 32'h0);
    chk("m0_irq_clr", {31'd0, bus.IRQ}, 32'd0);

    // Auto-reload, PRESET=3: pulses after E5, E11, E17; EN stays set.
    do_reset();
    cycle(1'b0, 1'b1, 2'd1, 32'd3);
    cycle(1'b0, 1'b1, 2'd0, 32'hB);             // E0
    for (int k = 1; k <= 20; k++) begin
      cycle(1'b0, 1'b0, 2'd0, 32'd0);
      chk("m1_ctrl", bus.Dout, 32'hB);
      chk("m1_irq", {31'd0, bus.IRQ}, (k == 5 || k == 11 || k == 17) ? 32'd1 : 32'd0);
    end

    // Disable mid-count freezes COUNT; re-enable reloads PRESET.
    do_reset();
    cycle(1'b0, 1'b1, 2'd1, 32'd6);
    cycle(1'b0, 1'b1, 2'd0, 32'h9);
    for (int k = 0; k < 5; k++) cycle(1'b0, 1'b0, 2'd2, 32'd0);
    cycle(1'b0, 1'b1, 2'd0, 32'h8);             // EN=0
    cycle(1'b0, 1'b0, 2'd2, 32'd0);
    frozen = bus.Dout;
    chk("frz_nonzero", {31'd0, (frozen != 32'd0)}, 32'd1);
    for (int k = 0; k < 10; k++) cycle(1'b0, 1'b0, 2'd2, 32'd0);
    chk("frz_count", bus.Dout, frozen);
    chk("frz_irq", {31'd0, bus.IRQ}, 32'd0);
    cycle(1'b0, 1'b1, 2'd0, 32'h9);             // E0 re-enable
    cycle(1'b0, 1'b0, 2'd2, 32'd0);
    cycle(1'b0, 1'b0, 2'd2, 32'd0);
    chk("reload", bus.Dout, 32'd6);

    // Masked expiry, then setting IM through a CTRL write clears the flag.
    do_reset();
    cycle(1'b0, 1'b1, 2'd1, 32'd2);
    cycle(1'b0, 1'b1, 2'd0, 32'h1);
    for (int k = 0; k < 8; k++) cycle(1'b0, 1'b0, 2'd0, 32'd0);
    chk("im0_ctrl", bus.Dout, 32'h0);
    chk("im0_irq", {31'd0, bus.IRQ}, 32'd0);
    cycle(1'b0, 1'b1, 2'd0, 32'h8);
    cycle(1'b0, 1'b0, 2'd0, 32'd0);
    chk("im1_irq", {31'd0, bus.IRQ}, 32'd0);

    // Reset mid-count with a simultaneous write aborts without IRQ.
    cycle(1'b0, 1'b1, 2'd1, 32'd8);
    cycle(1'b0, 1'b1, 2'd0, 32'h9);
    for (int k = 0; k < 5; k++) cycle(1'b0, 1'b0, 2'd2, 32'd0);
    cycle(1'b1, 1'b1, 2'd0, 32'h9);
    chk("rst_mid_ctrl", bus.Dout, 32'd0);
    for (int k = 0; k < 15; k++) cycle(1'b0, 1'b0, 2'd2, 32'd0);
    chk("rst_mid_cnt", bus.Dout, 32'd0);
    chk("rst_mid_irq", {31'd0, bus.IRQ}, 32'd0);

`ifdef TC_STATUS_EN
    // Status register: expiry sets bit 0, write-1-to-clear drops IRQ.
    cycle(1'b0, 1'b1, 2'd1, 32'd2);
    cycle(1'b0, 1'b1, 2'd0, 32'h9);
    for (int k = 0; k < 8; k++) cycle(1'b0, 1'b0, 2'd3, 32'd0);
    chk("stat_set", bus.Dout, 32'd1);
    cycle(1'b0, 1'b1, 2'd3, 32'd1);
    chk("stat_clr", bus.Dout, 32'd0);
    chk("stat_irq", {31'd0, bus.IRQ}, 32'd0);
`else
    cycle(1'b0, 1'b1, 2'd3, 32'hFFFF_FFFF);
    chk("rsvd_read", bus.Dout, 32'd0);
`endif

    // Randomized traffic, occasional reset.
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      logic [1:0]  a;
      logic [31:0] d;
      bit          r, we;
      a  = 2'($urandom_range(0, 3));
      r  = ($urandom_range(0, 299) == 0);
      we = ($urandom_range(0, 5) == 0);
      d  = $urandom;
      if (a == 2'd1) d = $urandom_range(0, 10);
      if (a == 2'd0 && $urandom_range(0, 2) != 0) d[0] = 1'b1;
      cycle(r, we, a, d);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/timer_counter.md
TIMER_COUNTER -- requirements
Module: timer_counter

Interface
REQ-001 SHALL have ports: clk  in  1  system clock, all state updates on rising edge.
REQ-002 SHALL have: reset  in  1  synchronous, active-high; forces all registers to reset values.
REQ-003 SHALL have: Addr  in  30  word address [31:2]; only Addr[3:2] decoded (0 CTRL, 1 PRESET, 2 COUNT, 3 reserved/STATUS).
REQ-004 SHALL have: WE  in  1  word write strobe, already qualified for this device and full byte enable.
REQ-005 SHALL have: Din  in  32  write data.
REQ-006 SHALL have: Dout  out  32  combinational read of the register selected by Addr[3:2].
REQ-007 SHALL have: IRQ  out  1  interrupt request to the CPU.

Function
REQ-008 CTRL SHALL be: [0] EN, [2:1] MODE, [3] IM; bits [31:4] read 0, writes ignored.
REQ-009 PRESET SHALL be 32-bit read/write; COUNT 32-bit read-only, writes to offset 2 ignored.
REQ-010 Writes SHALL commit at the edge where WE=1; the new value is visible on Dout the next cycle.
REQ-011 FSM states SHALL be IDLE, LOAD, CNT, INT.
REQ-012 IDLE: if EN=1 go LOAD at next edge, else stay; COUNT holds.
REQ-013 LOAD: COUNT <= PRESET, go CNT.
REQ-014 CNT: if EN=0 go IDLE with COUNT frozen; else if COUNT>1 decrement; else COUNT <= 0, set irq_flag, go INT.
REQ-015 INT, MODE=1: clear irq_flag, go IDLE (EN kept, auto-reload); IRQ pulse width exactly 1 cycle.
REQ-016 INT, MODE=0/2/3: clear CTRL.EN, go IDLE; irq_flag held until next CPU write to CTRL or PRESET.
REQ-017 IRQ SHALL equal irq_flag AND CTRL.IM, registered-state derived, no combinational path from Din.
REQ-018 Latency: EN written at edge E0 with PRESET=N (N>=1) SHALL give IRQ high after edge E(N+2); PRESET=0 behaves as N=1.
REQ-019 Mode 1 period SHALL be N+3 cycles between IRQ pulses.
REQ-020 Write to PRESET during CNT SHALL not alter COUNT until next LOAD.
REQ-021 CPU write to CTRL in the same cycle the FSM clears EN (INT, mode 0) SHALL win; written value is kept.
REQ-022 Reserved offset 3 SHALL read 0 when TC_STATUS_EN undefined.

Reset
REQ-023 On reset: CTRL=0, PRESET=0, COUNT=0, irq_flag=0, state=IDLE, IRQ=0, Dout=0 for Addr[3:2]=0.
REQ-024 Reset asserted mid-count SHALL abort at the next edge with no IRQ, overriding any simultaneous WE.

Configuration
REQ-025 Macro TC_STATUS_EN defined: offset 3 SHALL read {31'b0, irq_flag}; writing Din[0]=1 there clears irq_flag (write-1-to-clear), in addition to REQ-016 clearing.
REQ-026 Macro TC_STATUS_EN undefined: offset 3 reads 0, writes ignored; no extra logic.

Verification
REQ-027 Reset, read offsets 0..2 -> all 0, IRQ=0.
REQ-028 PRESET=5, CTRL=0x9 (EN,mode0,IM) at E0 -> COUNT reads 5,4,3,2,1,0; IRQ rises after E7, stays high; CTRL reads 0x8; write CTRL=0 -> IRQ low next cycle.
REQ-029 PRESET=3, CTRL=0xB (mode1,IM) -> 1-cycle IRQ pulses every 6 cycles, CTRL.EN remains 1.
REQ-030 Mode 0 counting, write CTRL.EN=0 when COUNT=2 -> COUNT frozen at 2, no IRQ; re-enable -> reloads PRESET.
REQ-031 IM=0, mode 0 expiry -> IRQ stays 0; later set IM=1 via CTRL write -> IRQ stays 0 (write cleared flag).
REQ-032 With TC_STATUS_EN: mode 0 expiry -> offset 3 reads 1; write 1 to offset 3 -> reads 0, IRQ low next cycle.
